beta_muldiv: RTL and testbench



---
 rtl/beta_muldiv.sv | 161 ++++++++++++++++
 tb/tb_beta_muldiv.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/beta_muldiv.sv
// beta_muldiv: iterative radix-2 multiply / divide / remainder unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
// The core starts an operation with a start strobe and stalls until done.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high; aborts any operation in flight
//   start   request strobe, accepted only while busy=0
//   op      00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM
//   sgn     1 = two's-complement operands, 0 = unsigned
//   a, b    multiplicand/dividend, multiplier/divisor
//   busy    operation in flight (RUN or FIX)
//   done    one-cycle pulse, result valid from this cycle
//   result  last completed result, held until the next done
//   dz      divide-by-zero flag of the last operation, held with result
module beta_muldiv #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d;   // dividend / multiplicand negative (sgn=1 only)
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] m_q, m_d;           // |b|: multiplicand or divisor
    logic [WIDTH-1:0] hi_q, hi_d;         // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;         // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] result_q, result_d;
    logic             dz_q, dz_d;

    // Magnitudes are formed one bit wider so the most-negative value
    // negates to exactly 2^(WIDTH-1).
    logic [WIDTH:0]     a_ext, b_ext, a_abs, b_abs;
    logic [WIDTH:0]     sum, trial;
    logic [WIDTH-1:0]   diff, q_s, r_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               unused_abs;

    assign a_ext = sgn ? {a[WIDTH-1], a} : {1'b0, a};
    assign b_ext = sgn ? {b[WIDTH-1], b} : {1'b0, b};
    assign a_abs = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_abs = b_ext[WIDTH] ? -b_ext : b_ext;
    assign unused_abs = a_abs[WIDTH] ^ b_abs[WIDTH];

    // Multiply step: conditionally add, then shift {carry,hi,lo} right.
    assign sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // Divide step: shift next dividend bit into the partial remainder.
    // The remainder stays below the divisor, so the difference fits WIDTH bits.
    assign trial = {hi_q, lo_q[WIDTH-1]};
    assign diff  = trial[WIDTH-1:0] - m_q;

    assign prod_s = (neg_a_q ^ neg_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign q_s    = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    // Negating |a| restores a itself, which also gives the divide-by-zero remainder.
    assign r_s    = neg_a_q ? -hi_q : hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d    = op;
                    neg_a_d = a_ext[WIDTH];
                    neg_b_d = b_ext[WIDTH];
                    lo_d    = a_abs[WIDTH-1:0];
                    m_d     = b_abs[WIDTH-1:0];
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!op_q[1]) begin
                        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
                    end else if (trial >= {1'b0, m_q}) begin
                        hi_d = diff;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = trial[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            FIX: begin
                dz_d = op_q[1] && (m_q == '0);
                case (op_q)
                    2'b00:   result_d = prod_s[WIDTH-1:0];
                    2'b01:   result_d = prod_s[2*WIDTH-1:WIDTH];
                    2'b10:   result_d = dz_d ? '1 : q_s;
                    default: result_d = r_s;
                endcase
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign busy   = (state_q == RUN) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_beta_muldiv.sv
// Directed bench for beta_muldiv (WIDTH=32): a vector table of operations
// with hand-computed results, then handshake and reset corner sequences.
module tb_beta_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, sgn;
    logic [1:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, dz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    beta_muldiv #(.WIDTH(W), .CW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .dz(dz)
    );

    typedef struct {
        logic [1:0]   op;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs right after acceptance, and
    // count edges from the accepting edge until done is seen.
    task automatic run_op(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] r,
                          output logic d, output int lat);
        @(negedge clk);
        op = o; sgn = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; sgn = ~s; a = ~x; b = y + 1;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        d = dz;
    endtask

    initial begin
        logic [W-1:0] r;
        logic         d;
        int           lat, ndone;
        logic [W-1:0] cap;

        tv[0]  = '{2'b00, 1'b1, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
        tv[1]  = '{2'b01, 1'b1, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 1'b0};
        tv[2]  = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        tv[3]  = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        tv[4]  = '{2'b10, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        tv[5]  = '{2'b11, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        tv[6]  = '{2'b10, 1'b0, 32'd100,      32'd7,        32'd14,       1'b0};
        tv[7]  = '{2'b10, 1'b1, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1};
        tv[8]  = '{2'b11, 1'b1, 32'h00001234, 32'd0,        32'h00001234, 1'b1};
        tv[9]  = '{2'b00, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0};
        tv[10] = '{2'b01, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0};
        tv[11] = '{2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        tv[12] = '{2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tv[13] = '{2'b10, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        tv[14] = '{2'b11, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0};
        tv[15] = '{2'b10, 1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1};
        tv[16] = '{2'b11, 1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};
        tv[17] = '{2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0};

        reset = 1'b1; start = 1'b0; op = '0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",   64'(busy),   64'd0);
        chk("reset done",   64'(done),   64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset dz",     64'(dz),     64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(tv[i].op, tv[i].sgn, tv[i].a, tv[i].b, r, d, lat);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(W + 2));
            chk($sformatf("v%0d result", i),  64'(r),   64'(tv[i].r));
            chk($sformatf("v%0d dz", i),      64'(d),   64'(tv[i].dz));
        end

        // Starts at cycles 3 and 10 of a busy period are ignored.
        @(negedge clk);
        op = 2'b00; sgn = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ndone = 0; cap = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = (cyc == 3 || cyc == 10);
            a = 32'd9; b = 32'd9;
            @(posedge clk); #1;
            if (cyc == 5) chk("busy mid-op", 64'(busy), 64'd1);
            if (done) begin
                ndone++;
                cap = result;
            end
        end
        start = 1'b0;
        chk("ignored start done count", 64'(ndone), 64'd1);
        chk("ignored start result",     64'(cap),   64'd15);

        // start held high through DONE: next operation accepted there.
        @(negedge clk);
        op = 2'b00; sgn = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        a = 32'd4; b = 32'd5;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held start first latency", 64'(lat),    64'(W + 2));
        chk("held start first result",  64'(result), 64'd6);
        chk("busy low in DONE",         64'(busy),   64'd0);
        @(posedge clk); #1;
        chk("busy back after DONE",     64'(busy),   64'd1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held start second latency", 64'(lat),    64'(W + 2));
        chk("held start second result",  64'(result), 64'd20);

        // Reset during RUN aborts the operation without a done pulse.
        @(negedge clk);
        op = 2'b00; sgn = 1'b0; a = 32'd7; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort busy",   64'(busy),   64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort done",   64'(done),   64'd0);
        chk("abort dz",     64'(dz),     64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        run_op(2'b00, 1'b0, 32'd7, 32'd7, r, d, lat);
        chk("post-abort latency", 64'(lat), 64'(W + 2));
        chk("post-abort result",  64'(r),   64'd49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
